// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 display constants, opcodes and draw sequencer state encoding
package chip8_pkg;

  localparam int DISP_ROWS = 32;
  localparam int DISP_COLS = 64;
  localparam int FONT_BASE = 80;

  localparam logic [15:0] OP_CLS      = 16'h00E0;
  localparam logic [15:0] OP_DRW      = 16'hD000;
  localparam logic [15:0] OP_DRW_MASK = 16'hF000;

  typedef logic [2:0] draw_state_t;

  localparam draw_state_t ST_IDLE  = 3'd0;
  localparam draw_state_t ST_FETCH = 3'd1;
  localparam draw_state_t ST_WRITE = 3'd2;
  localparam draw_state_t ST_CLEAR = 3'd3;
  localparam draw_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/chip8_draw_sequencer_if.sv
// rtl/chip8_draw_sequencer_if.sv - program memory and display RAM ports of the draw sequencer
interface chip8_draw_sequencer_if #(
  parameter int DISP_COLS = 64,
  parameter int ROW_W     = 5,
  parameter int ADDR_W    = 12
);

  logic                 mem_req;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_gnt;
  logic [7:0]           mem_rdata;
  logic                 disp_rd_en;
  logic [ROW_W-1:0]     disp_rd_row;
  logic [DISP_COLS-1:0] disp_rd_data;
  logic                 disp_wr_en;
  logic [ROW_W-1:0]     disp_wr_row;
  logic [DISP_COLS-1:0] disp_wr_data;

  modport master (
    output mem_req, mem_addr, disp_rd_en, disp_rd_row, disp_wr_en, disp_wr_row, disp_wr_data,
    input  mem_gnt, mem_rdata, disp_rd_data
  );

  modport slave (
    input  mem_req, mem_addr, disp_rd_en, disp_rd_row, disp_wr_en, disp_wr_row, disp_wr_data,
    output mem_gnt, mem_rdata, disp_rd_data
  );

endinterface

// File: rtl/chip8_sprite_row.sv
// rtl/chip8_sprite_row.sv - XORs one sprite byte into a display row at column x, with wrap
module chip8_sprite_row #(
  parameter int DISP_COLS = 64
) (
  input  logic [$clog2(DISP_COLS)-1:0] x,
  input  logic [7:0]                   sprite_byte,
  input  logic [DISP_COLS-1:0]         row,
  output logic [DISP_COLS-1:0]         new_row,
  output logic                         hit
);

  localparam int X_W = $clog2(DISP_COLS);

  logic [DISP_COLS-1:0] aligned;
  logic [DISP_COLS-1:0] shifted;

  // Column 0 is the row MSB; a right rotate by x puts the byte MSB at column x.
  always_comb begin
    aligned = {sprite_byte, {(DISP_COLS-8){1'b0}}};
    shifted = (aligned >> x) | (aligned << (X_W'(DISP_COLS) - x));
    new_row = row ^ shifted;
    hit     = |(row & shifted);
  end

endmodule

// File: rtl/chip8_draw_sequencer.sv
// rtl/chip8_draw_sequencer.sv - multi-cycle DRW/CLS sequencer: fetches sprite bytes,
// read-modify-writes display rows and accumulates the VF collision flag
module chip8_draw_sequencer #(
  parameter int DISP_ROWS = chip8_pkg::DISP_ROWS,
  parameter int DISP_COLS = chip8_pkg::DISP_COLS,
  parameter int ADDR_W    = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         draw_start,
  input  logic [$clog2(DISP_COLS)-1:0] draw_x,
  input  logic [$clog2(DISP_ROWS)-1:0] draw_y,
  input  logic [3:0]                   draw_n,
  input  logic [ADDR_W-1:0]            draw_i,
  input  logic                         clr_start,
  output logic                         busy,
  output logic                         done,
  output logic                         collision,
  chip8_draw_sequencer_if.master       bus
);

  import chip8_pkg::*;

  localparam int X_W   = $clog2(DISP_COLS);
  localparam int ROW_W = $clog2(DISP_ROWS);

  draw_state_t          state;
  logic [ROW_W-1:0]     r;
  logic [X_W-1:0]       x_q;
  logic [ROW_W-1:0]     y_q;
  logic [3:0]           n_q;
  logic [ADDR_W-1:0]    i_q;
  logic                 coll_q;
  logic [ROW_W-1:0]     row_idx;
  logic [DISP_COLS-1:0] new_row;
  logic                 hit;

  // Row index wraps naturally at the power-of-two display height.
  assign row_idx   = y_q + r;
  assign collision = coll_q;

  chip8_sprite_row #(.DISP_COLS(DISP_COLS)) u_sprite_row (
    .x           (x_q),
    .sprite_byte (bus.mem_rdata),
    .row         (bus.disp_rd_data),
    .new_row     (new_row),
    .hit         (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      r      <= '0;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      i_q    <= '0;
      coll_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            r     <= '0;
            state <= ST_CLEAR;
          end else if (draw_start) begin
            x_q    <= draw_x;
            y_q    <= draw_y;
            n_q    <= draw_n;
            i_q    <= draw_i;
            coll_q <= 1'b0;
            r      <= '0;
            state  <= (draw_n == 4'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.mem_gnt) state <= ST_WRITE;
        end
        ST_WRITE: begin
          coll_q <= coll_q | hit;
          r      <= r + 1'b1;
          state  <= (r == ROW_W'(n_q - 4'd1)) ? ST_DONE : ST_FETCH;
        end
        ST_CLEAR: begin
          r <= r + 1'b1;
          if (r == ROW_W'(DISP_ROWS - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (state != ST_IDLE);
    done             = (state == ST_DONE);
    bus.mem_req      = (state == ST_FETCH);
    bus.mem_addr     = (state == ST_FETCH) ? i_q + ADDR_W'(r) : '0;
    bus.disp_rd_en   = (state == ST_FETCH) && bus.mem_gnt;
    bus.disp_rd_row  = bus.disp_rd_en ? row_idx : '0;
    bus.disp_wr_en   = (state == ST_WRITE) || (state == ST_CLEAR);
    bus.disp_wr_row  = (state == ST_WRITE) ? row_idx : ((state == ST_CLEAR) ? r : '0);
    bus.disp_wr_data = (state == ST_WRITE) ? new_row : '0;
  end

endmodule

// File: tb/tb_chip8_draw_sequencer.sv
// tb/tb_chip8_draw_sequencer.sv - directed bench for the DRW/CLS draw sequencer
module tb_chip8_draw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw_start = 1'b0;
  logic        clr_start = 1'b0;
  logic [5:0]  draw_x = '0;
  logic [4:0]  draw_y = '0;
  logic [3:0]  draw_n = '0;
  logic [11:0] draw_i = '0;
  logic        busy, done, collision;

  always #5 clk = ~clk;

  chip8_draw_sequencer_if #(.DISP_COLS(64), .ROW_W(5), .ADDR_W(12)) bus ();

  chip8_draw_sequencer #(.DISP_ROWS(32), .DISP_COLS(64), .ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .draw_start (draw_start),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_n     (draw_n),
    .draw_i     (draw_i),
    .clr_start  (clr_start),
    .busy       (busy),
    .done       (done),
    .collision  (collision),
    .bus        (bus)
  );

  logic [5:0]  ref_x = '0;
  logic [7:0]  ref_byte = '0;
  logic [63:0] ref_row = '0;
  logic [63:0] ref_new;
  logic        ref_hit;

  chip8_sprite_row #(.DISP_COLS(64)) u_ref (
    .x           (ref_x),
    .sprite_byte (ref_byte),
    .row         (ref_row),
    .new_row     (ref_new),
    .hit         (ref_hit)
  );

  logic [7:0]  mem  [0:4095];
  logic [63:0] disp [0:31];

  logic        fill_req = 1'b0;
  logic [63:0] fill_val = '0;
  logic        stall_load = 1'b0;
  int          stall_cfg = 0;
  logic [11:0] stall_addr = '0;
  int          stall_left = 0;
  int          wr_cnt = 0, done_cnt = 0, req_cnt = 0, clash_cnt = 0, stall_cnt = 0, hold_viol = 0;
  logic        held_valid = 1'b0;
  logic [11:0] held_addr = '0;

  int checks = 0;
  int errors = 0;

  assign bus.mem_gnt = bus.mem_req && !(bus.mem_addr == stall_addr && stall_left != 0);

  // Memory and display models plus activity counters.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.disp_rd_en) bus.disp_rd_data <= disp[bus.disp_rd_row];
    if (fill_req) begin
      for (int k = 0; k < 32; k++) disp[k] <= fill_val;
    end else if (bus.disp_wr_en) begin
      disp[bus.disp_wr_row] <= bus.disp_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.disp_rd_en && bus.disp_wr_en && bus.disp_rd_row == bus.disp_wr_row) clash_cnt <= clash_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.mem_req) req_cnt <= req_cnt + 1;
    if (held_valid && !(bus.mem_req && bus.mem_addr == held_addr)) hold_viol <= hold_viol + 1;
    held_valid <= bus.mem_req && !bus.mem_gnt;
    held_addr  <= bus.mem_addr;
    if (stall_load) stall_left <= stall_cfg;
    else if (bus.mem_req && !bus.mem_gnt) begin
      stall_left <= stall_left - 1;
      stall_cnt  <= stall_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [63:0] v);
    @(negedge clk);
    fill_val = v;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic start(input bit d, input bit c, input logic [5:0] x, input logic [4:0] y,
                       input logic [3:0] n, input logic [11:0] i);
    @(negedge clk);
    draw_start = d;
    clr_start  = c;
    draw_x = x;
    draw_y = y;
    draw_n = n;
    draw_i = i;
    @(negedge clk);
    draw_start = 1'b0;
    clr_start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int lat, w0, d0, r0, s0;
    logic [7:0] glyph [0:4];
    glyph[0] = 8'hF0; glyph[1] = 8'h90; glyph[2] = 8'h90; glyph[3] = 8'h90; glyph[4] = 8'hF0;

    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    for (int k = 0; k < 5; k++) mem[80 + k] = glyph[k];
    for (int k = 0; k < 3; k++) mem[300 + k] = 8'hFF;
    mem[200] = 8'hA5;
    mem[201] = 8'h3C;
    for (int k = 0; k < 8; k++) mem[400 + k] = 8'(1 << k);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, collision, bus.mem_req, bus.disp_rd_en, bus.disp_wr_en}, 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    rst_n = 1'b1;
    fill(64'd0);

    // Sprite row reference
    ref_x = 6'd60; ref_byte = 8'hFF; ref_row = 64'd0;
    #1;
    check("ref_wrap_row", ref_new, 64'hF000_0000_0000_000F);
    check("ref_wrap_hit", 64'(ref_hit), 64'd0);
    ref_x = 6'd4; ref_byte = 8'h81; ref_row = 64'h0800_0000_0000_0000;
    #1;
    check("ref_hit_row", ref_new, 64'h0010_0000_0000_0000);
    check("ref_hit_hit", 64'(ref_hit), 64'd1);

    // Test 1: "0" glyph on blank display
    start(1'b1, 1'b0, 6'd0, 5'd0, 4'd5, 12'd80);
    wait_done(lat);
    check("t1_latency", 64'(lat), 64'd11);
    check("t1_collision", 64'(collision), 64'd0);
    for (int k = 0; k < 5; k++) check("t1_row", disp[k], {glyph[k], 56'd0});
    check("t1_row5", disp[5], 64'd0);

    // Test 2: redraw erases and collides
    start(1'b1, 1'b0, 6'd0, 5'd0, 4'd5, 12'd80);
    wait_done(lat);
    check("t2_latency", 64'(lat), 64'd11);
    check("t2_collision", 64'(collision), 64'd1);
    for (int k = 0; k < 5; k++) check("t2_row", disp[k], 64'd0);

    // Test 5: simultaneous starts, clear wins, later draw ignored
    fill(64'hDEAD_BEEF_0123_4567);
    w0 = wr_cnt; d0 = done_cnt; r0 = req_cnt;
    @(negedge clk);
    draw_start = 1'b1; clr_start = 1'b1;
    draw_x = 6'd0; draw_y = 5'd0; draw_n = 4'd5; draw_i = 12'd80;
    @(negedge clk);
    draw_start = 1'b0; clr_start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      draw_start = (lat == 4);
      @(negedge clk);
      lat++;
    end
    draw_start = 1'b0;
    check("t5_latency", 64'(lat), 64'd33);
    check("t5_collision_kept", 64'(collision), 64'd1);
    repeat (4) @(negedge clk);
    check("t5_busy_after", 64'(busy), 64'd0);
    check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t5_writes", 64'(wr_cnt - w0), 64'd32);
    check("t5_no_fetch", 64'(req_cnt - r0), 64'd0);
    for (int k = 0; k < 32; k++) check("t5_row_zero", disp[k], 64'd0);

    // n == 0 draw
    w0 = wr_cnt;
    start(1'b1, 1'b0, 6'd3, 5'd3, 4'd0, 12'd80);
    wait_done(lat);
    check("n0_latency", 64'(lat), 64'd1);
    check("n0_collision", 64'(collision), 64'd0);
    check("n0_no_write", 64'(wr_cnt - w0), 64'd0);

    // Test 3: row and column wrap
    start(1'b1, 1'b0, 6'd60, 5'd30, 4'd3, 12'd300);
    wait_done(lat);
    check("t3_latency", 64'(lat), 64'd7);
    check("t3_collision", 64'(collision), 64'd0);
    check("t3_row30", disp[30], 64'hF000_0000_0000_000F);
    check("t3_row31", disp[31], 64'hF000_0000_0000_000F);
    check("t3_row0", disp[0], 64'hF000_0000_0000_000F);
    check("t3_row1", disp[1], 64'd0);
    check("t3_row29", disp[29], 64'd0);

    // Test 4: seven-cycle grant stall on the second row
    s0 = stall_cnt;
    stall_cfg = 7;
    stall_addr = 12'd201;
    @(negedge clk); stall_load = 1'b1;
    @(negedge clk); stall_load = 1'b0;
    start(1'b1, 1'b0, 6'd16, 5'd10, 4'd2, 12'd200);
    wait_done(lat);
    check("t4_latency", 64'(lat), 64'd12);
    check("t4_stall_cycles", 64'(stall_cnt - s0), 64'd7);
    check("t4_hold_stable", 64'(hold_viol), 64'd0);
    check("t4_row10", disp[10], 64'h0000_A500_0000_0000);
    check("t4_row11", disp[11], 64'h0000_3C00_0000_0000);
    check("t4_collision", 64'(collision), 64'd0);

    // Test 6: reset during the third row
    fill(64'd0);
    start(1'b1, 1'b0, 6'd0, 5'd0, 4'd8, 12'd400);
    lat = 0;
    while (!(bus.mem_req && bus.mem_addr == 12'd402) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("t6_reach_row2", 64'(bus.mem_addr), 64'd402);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {busy, done, collision, bus.mem_req, bus.disp_rd_en, bus.disp_wr_en}, 64'd0);
    check("t6_rst_addr", 64'(bus.mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    check("t6_rst_hold", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_after", 64'(busy), 64'd0);
    check("t6_row0", disp[0], 64'h0100_0000_0000_0000);
    check("t6_row1", disp[1], 64'h0200_0000_0000_0000);
    for (int k = 2; k < 8; k++) check("t6_row_untouched", disp[k], 64'd0);
    start(1'b1, 1'b0, 6'd0, 5'd0, 4'd8, 12'd400);
    wait_done(lat);
    check("t6_redraw_latency", 64'(lat), 64'd17);
    check("t6_redraw_collision", 64'(collision), 64'd1);
    check("t6_redraw_row0", disp[0], 64'd0);
    check("t6_redraw_row1", disp[1], 64'd0);
    for (int k = 2; k < 8; k++) check("t6_redraw_row", disp[k], {8'(1 << k), 56'd0});

    check("no_rw_clash", 64'(clash_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
